// File: rtl/vga_field_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_field_renderer
// Desc     : Maps active VGA pixels onto Game-of-Life cells, reads the cell
//            state from the field RAM and emits 12-bit RGB with aligned syncs
//            and a once-per-frame start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module vga_field_renderer #(
  parameter int          VGA_H_ACTIVE = 640,
  parameter int          VGA_V_ACTIVE = 480,
  parameter int          FIELD_W      = 80,
  parameter int          FIELD_H      = 60,
  parameter int          CELL_PX      = 8,
  parameter int          GRID_EN      = 1,
  parameter logic [11:0] C_ALIVE      = 12'hFFF,
  parameter logic [11:0] C_DEAD       = 12'h000,
  parameter logic [11:0] C_GRID       = 12'h333,
  parameter logic [11:0] C_BORDER     = 12'h00F,
  localparam int         ADDR_W       = $clog2(FIELD_W * FIELD_H),
  localparam int         X_W          = $clog2(VGA_H_ACTIVE),
  localparam int         Y_W          = $clog2(VGA_V_ACTIVE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_draw_active,
  input  logic [X_W-1:0]    i_active_x,
  input  logic [Y_W-1:0]    i_active_y,
  input  logic              i_h_sync,
  input  logic              i_v_sync,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_data,
  output logic [11:0]       o_rgb,
  output logic              o_h_sync,
  output logic              o_v_sync,
  output logic              o_frame_start
);

  // Counter widths: the cell counters must be able to hold the saturation
  // value FIELD_W / FIELD_H, one past the last valid cell.
  localparam int SUB_W = $clog2(CELL_PX);
  localparam int CX_W  = $clog2(FIELD_W + 1);
  localparam int CY_W  = $clog2(FIELD_H + 1);

  localparam logic [SUB_W-1:0]  c_sub_last   = SUB_W'(CELL_PX - 1);
  localparam logic [CX_W-1:0]   c_cell_x_lim = CX_W'(FIELD_W);
  localparam logic [CY_W-1:0]   c_cell_y_lim = CY_W'(FIELD_H);
  localparam logic [X_W-1:0]    c_x_last     = X_W'(VGA_H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] c_field_w    = ADDR_W'(FIELD_W);

  logic [SUB_W-1:0]  r_sub_x, r_sub_y, w_sub_x_nxt, w_sub_y_nxt;
  logic [CX_W-1:0]   r_cell_x, w_cell_x_nxt;
  logic [CY_W-1:0]   r_cell_y, w_cell_y_nxt;

  logic              r_hs1, r_hs2, r_vs1, r_vs2;
  logic              r_act1, r_act2, r_inf1, r_inf2, r_grid1, r_grid2;

  logic              w_h_fall, w_v_fall, w_line_end;
  logic              w_in_field, w_grid;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  // The vertical position is tracked by counting lines, so the y coordinate
  // from the timing generator is not needed.
  assign w_unused = ^i_active_y;

  // First sync delay stage doubles as the previous sample for edge detection.
  assign w_h_fall   = r_hs1 & ~i_h_sync;
  assign w_v_fall   = r_vs1 & ~i_v_sync;
  assign w_line_end = i_draw_active && (i_active_x == c_x_last);

  assign w_in_field = (r_cell_x < c_cell_x_lim) && (r_cell_y < c_cell_y_lim);
  assign w_grid     = (GRID_EN != 0) && ((r_sub_x == '0) || (r_sub_y == '0));
  assign w_addr     = w_in_field ?
                      (ADDR_W'(r_cell_y) * c_field_w + ADDR_W'(r_cell_x)) : '0;

  // Position counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_x  <= '0;
      r_cell_x <= '0;
      r_sub_y  <= '0;
      r_cell_y <= '0;
    end else begin
      r_sub_x  <= w_sub_x_nxt;
      r_cell_x <= w_cell_x_nxt;
      r_sub_y  <= w_sub_y_nxt;
      r_cell_y <= w_cell_y_nxt;
    end
  end

  // Horizontal counters: clear on hsync fall, step once per active pixel.
  always_comb begin
    w_sub_x_nxt  = r_sub_x;
    w_cell_x_nxt = r_cell_x;
    if (w_h_fall) begin
      w_sub_x_nxt  = '0;
      w_cell_x_nxt = '0;
    end else if (i_draw_active) begin
      if (r_sub_x == c_sub_last) begin
        w_sub_x_nxt = '0;
        if (r_cell_x != c_cell_x_lim) begin
          w_cell_x_nxt = r_cell_x + 1'b1;
        end
      end else begin
        w_sub_x_nxt = r_sub_x + 1'b1;
      end
    end
  end

  // Vertical counters: clear on vsync fall, step on the last pixel of a line.
  always_comb begin
    w_sub_y_nxt  = r_sub_y;
    w_cell_y_nxt = r_cell_y;
    if (w_v_fall) begin
      w_sub_y_nxt  = '0;
      w_cell_y_nxt = '0;
    end else if (w_line_end) begin
      if (r_sub_y == c_sub_last) begin
        w_sub_y_nxt = '0;
        if (r_cell_y != c_cell_y_lim) begin
          w_cell_y_nxt = r_cell_y + 1'b1;
        end
      end else begin
        w_sub_y_nxt = r_sub_y + 1'b1;
      end
    end
  end

  // Stage 1: issue the RAM read and register the pixel classification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_addr <= '0;
      r_act1    <= 1'b0;
      r_inf1    <= 1'b0;
      r_grid1   <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
    end else begin
      o_rd_addr <= w_addr;
      r_act1    <= i_draw_active;
      r_inf1    <= w_in_field;
      r_grid1   <= w_grid;
      r_hs1     <= i_h_sync;
      r_vs1     <= i_v_sync;
    end
  end

  // Stage 2: hold the flags while the RAM returns the cell state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act2  <= 1'b0;
      r_inf2  <= 1'b0;
      r_grid2 <= 1'b0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
    end else begin
      r_act2  <= r_act1;
      r_inf2  <= r_inf1;
      r_grid2 <= r_grid1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
    end
  end

  // Stage 3: colour selection by priority and final sync alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rgb    <= 12'h000;
      o_h_sync <= 1'b1;
      o_v_sync <= 1'b1;
    end else begin
      o_h_sync <= r_hs2;
      o_v_sync <= r_vs2;
      if (!r_act2) begin
        o_rgb <= 12'h000;
      end else if (!r_inf2) begin
        o_rgb <= C_BORDER;
      end else if (r_grid2) begin
        o_rgb <= C_GRID;
      end else begin
        o_rgb <= i_rd_data ? C_ALIVE : C_DEAD;
      end
    end
  end

  // One-cycle pulse after each vsync falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= w_v_fall;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_field_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_field_renderer
// Desc     : Directed self-checking bench for vga_field_renderer: an 80-wide
//            and a 70-wide instance share one compressed timing stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_field_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        draw_active;
  logic [9:0]  active_x;
  logic [8:0]  active_y;
  logic        h_sync, v_sync;
  logic [12:0] addr_a, addr_b;
  logic        rd_a, rd_b;
  logic [11:0] rgb_a, rgb_b;
  logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  logic        field_a [4800];
  logic        field_b [4200];

  int checks   = 0;
  int errors   = 0;
  int fs_cnt_a = 0;
  int fs_cnt_b = 0;

  typedef struct {
    logic        val;
    logic        act;
    logic        chk;
    logic        hs;
    logic        vs;
    int          x;
    int          y;
    logic [11:0] rgb_a;
    logic [11:0] rgb_b;
    logic [12:0] addr_a;
    logic [12:0] addr_b;
  } hist_t;

  // p[0] = inputs sampled at the latest edge, p[2] = two edges earlier
  hist_t p [3];

  always #5 clk = ~clk;

  vga_field_renderer dut_a (
    .clk(clk), .rst_n(rst_n), .i_draw_active(draw_active),
    .i_active_x(active_x), .i_active_y(active_y),
    .i_h_sync(h_sync), .i_v_sync(v_sync),
    .o_rd_addr(addr_a), .i_rd_data(rd_a), .o_rgb(rgb_a),
    .o_h_sync(hs_a), .o_v_sync(vs_a), .o_frame_start(fs_a)
  );

  vga_field_renderer #(.FIELD_W(70)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_draw_active(draw_active),
    .i_active_x(active_x), .i_active_y(active_y),
    .i_h_sync(h_sync), .i_v_sync(v_sync),
    .o_rd_addr(addr_b), .i_rd_data(rd_b), .o_rgb(rgb_b),
    .o_h_sync(hs_b), .o_v_sync(vs_b), .o_frame_start(fs_b)
  );

  // Synchronous field RAMs, one cycle read latency
  always @(posedge clk) begin
    rd_a <= (addr_a < 13'd4800) ? field_a[addr_a] : 1'b0;
    rd_b <= (addr_b < 13'd4200) ? field_b[addr_b] : 1'b0;
  end

  // Frame start pulse counters
  always @(posedge clk) begin
    if (fs_a === 1'b1) fs_cnt_a <= fs_cnt_a + 1;
    if (fs_b === 1'b1) fs_cnt_b <= fs_cnt_b + 1;
  end

  function automatic logic [11:0] exp_rgb(input logic act, input int x, input int y,
                                          input int fw, input int fh, input logic alive);
    if (!act) return 12'h000;
    if ((x / 8) >= fw || (y / 8) >= fh) return 12'h00F;
    if ((x % 8) == 0 || (y % 8) == 0) return 12'h333;
    return alive ? 12'hFFF : 12'h000;
  endfunction

  // Drive one pixel clock and record the expected results for it
  task automatic tick(input logic act, input int x, input int y, input logic hs,
                      input logic vs, input logic chk);
    hist_t h;
    int    cx, cy;
    logic  alive_a, alive_b;
    draw_active = act;
    active_x    = act ? 10'(x) : 10'd0;
    active_y    = act ? 9'(y) : 9'd0;
    h_sync      = hs;
    v_sync      = vs;
    cx = x / 8;
    cy = y / 8;
    alive_a  = 1'b0;
    alive_b  = 1'b0;
    h.addr_a = '0;
    h.addr_b = '0;
    if (cx < 80 && cy < 60) begin
      alive_a  = field_a[cy * 80 + cx];
      h.addr_a = 13'(cy * 80 + cx);
    end
    if (cx < 70 && cy < 60) begin
      alive_b  = field_b[cy * 70 + cx];
      h.addr_b = 13'(cy * 70 + cx);
    end
    h.val   = 1'b1;
    h.act   = act;
    h.chk   = !act || chk;
    h.hs    = hs;
    h.vs    = vs;
    h.x     = x;
    h.y     = y;
    h.rgb_a = exp_rgb(act, x, y, 80, 60, alive_a);
    h.rgb_b = exp_rgb(act, x, y, 70, 60, alive_b);
    p[2] = p[1];
    p[1] = p[0];
    p[0] = h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_hist();
    for (int i = 0; i < 3; i++) p[i].val = 1'b0;
  endtask

  task automatic hblank(input logic vs);
    for (int c = 0; c < 8; c++) tick(1'b0, 0, 0, !(c >= 2 && c < 6), vs, 1'b1);
  endtask

  task automatic vsync_seq();
    hblank(1'b1);
    hblank(1'b0);
    hblank(1'b0);
    hblank(1'b1);
  endtask

  // Compressed line: only the last active pixel, enough to step the row
  task automatic fast_line(input int y);
    tick(1'b1, 639, y, 1'b1, 1'b1, 1'b0);
    hblank(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1'($urandom % 2), $urandom_range(0, 639), $urandom_range(0, 479),
           1'($urandom % 2), 1'($urandom % 2), 1'b0);
      checks++;
      if ({rgb_a, hs_a, vs_a, fs_a, addr_a} !== {12'h000, 3'b110, 13'd0}) begin
        errors++;
        $display("FAIL reset_a: got rgb=%h hs=%b vs=%b fs=%b addr=%0d, expected 000 1 1 0 0",
                 rgb_a, hs_a, vs_a, fs_a, addr_a);
      end
      checks++;
      if ({rgb_b, hs_b, vs_b, fs_b, addr_b} !== {12'h000, 3'b110, 13'd0}) begin
        errors++;
        $display("FAIL reset_b: got rgb=%h hs=%b vs=%b fs=%b addr=%0d, expected 000 1 1 0 0",
                 rgb_b, hs_b, vs_b, fs_b, addr_b);
      end
    end
    tick(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    reset_hist();
    for (int i = 0; i < 4; i++) tick(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_alive_cell();
    vsync_seq();
    for (int ln = 0; ln < 2; ln++) begin
      for (int c = 0; c < 648; c++) begin
        tick(c < 640, c < 640 ? c : 0, ln, !(c >= 642 && c < 646), 1'b1, 1'b1);
        if (p[0].val && p[0].act && p[0].x == 1 && p[0].y == 1) begin
          checks++;
          if (addr_a !== 13'd0 || addr_b !== 13'd0) begin
            errors++;
            $display("FAIL alive_addr: got %0d/%0d expected 0/0", addr_a, addr_b);
          end
        end
        if (p[2].val && p[2].act && p[2].x == 1 && p[2].y == 1) begin
          checks++;
          if (rgb_a !== 12'hFFF || rgb_b !== 12'hFFF) begin
            errors++;
            $display("FAIL alive_rgb: got %h/%h expected fff/fff", rgb_a, rgb_b);
          end
        end
        if (p[2].val && p[2].act && p[2].x == 0 && p[2].y == 0) begin
          checks++;
          if (rgb_a !== 12'h333) begin
            errors++;
            $display("FAIL grid_origin_rgb: got %h expected 333", rgb_a);
          end
        end
      end
    end
  endtask

  task automatic test_cell_mapping();
    logic [11:0] e15;
    logic [11:0] e82;
    e15 = field_a[1] ? 12'hFFF : 12'h000;
    e82 = field_a[82] ? 12'hFFF : 12'h000;
    vsync_seq();
    for (int ln = 0; ln < 10; ln++) begin
      for (int c = 0; c < 648; c++) begin
        tick(c < 640, c < 640 ? c : 0, ln, !(c >= 642 && c < 646), 1'b1, 1'b1);
        if (p[0].val && p[0].act) begin
          if (p[0].x == 15 && p[0].y == 1) begin
            checks++;
            if (addr_a !== 13'd1) begin
              errors++;
              $display("FAIL map_x15_addr: got %0d expected 1", addr_a);
            end
          end
          if (p[0].x == 16 && p[0].y == 1) begin
            checks++;
            if (addr_a !== 13'd2) begin
              errors++;
              $display("FAIL map_x16_addr: got %0d expected 2", addr_a);
            end
          end
          if (p[0].x == 17 && (p[0].y == 8 || p[0].y == 9)) begin
            checks++;
            if (addr_a !== 13'd82) begin
              errors++;
              $display("FAIL map_x17_y%0d_addr: got %0d expected 82", p[0].y, addr_a);
            end
          end
        end
        if (p[2].val && p[2].act) begin
          if (p[2].x == 15 && p[2].y == 1) begin
            checks++;
            if (rgb_a !== e15) begin
              errors++;
              $display("FAIL map_x15_rgb: got %h expected %h", rgb_a, e15);
            end
          end
          if (p[2].x == 16 && p[2].y == 1) begin
            checks++;
            if (rgb_a !== 12'h333) begin
              errors++;
              $display("FAIL map_x16_rgb: got %h expected 333", rgb_a);
            end
          end
          if (p[2].x == 17 && p[2].y == 9) begin
            checks++;
            if (rgb_a !== e82) begin
              errors++;
              $display("FAIL map_x17_y9_rgb: got %h expected %h", rgb_a, e82);
            end
          end
        end
      end
    end
  endtask

  task automatic test_border_70();
    int max_b;
    max_b = 0;
    vsync_seq();
    for (int ln = 0; ln < 472; ln++) fast_line(ln);
    for (int ln = 472; ln < 480; ln++) begin
      for (int c = 0; c < 648; c++) begin
        tick(c < 640, c < 640 ? c : 0, ln, !(c >= 642 && c < 646), 1'b1, 1'b1);
        if (p[0].val && p[0].act) begin
          if (int'(addr_b) > max_b) max_b = int'(addr_b);
          if (p[0].x >= 560) begin
            checks++;
            if (addr_b !== 13'd0) begin
              errors++;
              $display("FAIL border70_addr x=%0d y=%0d: got %0d expected 0", p[0].x, p[0].y, addr_b);
            end
          end
          if (p[0].x == 639 && p[0].y == 479) begin
            checks++;
            if (addr_a !== 13'd4799) begin
              errors++;
              $display("FAIL last_cell_addr_a: got %0d expected 4799", addr_a);
            end
          end
        end
        if (p[2].val && p[2].act && p[2].x >= 560) begin
          checks++;
          if (rgb_b !== 12'h00F) begin
            errors++;
            $display("FAIL border70_rgb x=%0d y=%0d: got %h expected 00f", p[2].x, p[2].y, rgb_b);
          end
        end
      end
    end
    checks++;
    if (max_b != 4199) begin
      errors++;
      $display("FAIL border70_max_addr: got %0d expected 4199", max_b);
    end
  endtask

  // Row selection for the frame: full-width rows are fully scoreboarded,
  // the remaining rows are compressed to keep the run short.
  function automatic bit full_row(input int y);
    return (y < 8) || (y >= 240 && y < 244) || (y >= 472);
  endfunction

  task automatic test_full_frame(input string tag);
    int   fs0_a, fs0_b, na;
    logic vs_l, full, act;
    fs0_a = fs_cnt_a;
    fs0_b = fs_cnt_b;
    for (int ln = -4; ln < 481; ln++) begin
      vs_l = (ln == -3 || ln == -2) ? 1'b0 : 1'b1;
      full = (ln >= 0 && ln < 480) && full_row(ln);
      na   = (ln < 0 || ln >= 480) ? 0 : (full ? 640 : 1);
      for (int c = 0; c < na + 8; c++) begin
        act = (c < na);
        tick(act, act ? (full ? c : 639) : 0, (ln < 0) ? 0 : ln,
             !(c >= na + 2 && c < na + 6), vs_l, full);
        if (p[2].val && p[2].chk) begin
          checks++;
          if (rgb_a !== p[2].rgb_a || rgb_b !== p[2].rgb_b) begin
            errors++;
            $display("FAIL %s rgb x=%0d y=%0d: got %h/%h expected %h/%h",
                     tag, p[2].x, p[2].y, rgb_a, rgb_b, p[2].rgb_a, p[2].rgb_b);
          end
        end
        if (p[0].val && p[0].act && p[0].chk) begin
          checks++;
          if (addr_a !== p[0].addr_a || addr_b !== p[0].addr_b) begin
            errors++;
            $display("FAIL %s addr x=%0d y=%0d: got %0d/%0d expected %0d/%0d",
                     tag, p[0].x, p[0].y, addr_a, addr_b, p[0].addr_a, p[0].addr_b);
          end
        end
        if (p[2].val) begin
          checks++;
          if ({hs_a, vs_a, hs_b, vs_b} !== {p[2].hs, p[2].vs, p[2].hs, p[2].vs}) begin
            errors++;
            $display("FAIL %s sync_delay: got hs/vs %b%b %b%b expected %b%b",
                     tag, hs_a, vs_a, hs_b, vs_b, p[2].hs, p[2].vs);
          end
        end
        if (p[1].val) begin
          checks++;
          if (fs_a !== (p[1].vs & ~p[0].vs) || fs_b !== (p[1].vs & ~p[0].vs)) begin
            errors++;
            $display("FAIL %s frame_start: got %b/%b expected %b",
                     tag, fs_a, fs_b, p[1].vs & ~p[0].vs);
          end
        end
        checks++;
        if (!(addr_a <= 13'd4799 && addr_b <= 13'd4199)) begin
          errors++;
          $display("FAIL %s addr_range: got %0d/%0d expected <=4799/<=4199", tag, addr_a, addr_b);
        end
      end
    end
    checks++;
    if (fs_cnt_a - fs0_a != 1 || fs_cnt_b - fs0_b != 1) begin
      errors++;
      $display("FAIL %s frame_start_count: got %0d/%0d expected 1/1",
               tag, fs_cnt_a - fs0_a, fs_cnt_b - fs0_b);
    end
  endtask

  task automatic test_mid_reset();
    vsync_seq();
    for (int ln = 0; ln < 200; ln++) fast_line(ln);
    for (int c = 0; c < 300; c++) tick(1'b1, c, 200, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rgb_a, hs_a, vs_a, fs_a, addr_a} !== {12'h000, 3'b110, 13'd0} ||
          {rgb_b, hs_b, vs_b, fs_b, addr_b} !== {12'h000, 3'b110, 13'd0}) begin
        errors++;
        $display("FAIL mid_reset cycle %0d: got rgb=%h/%h hs=%b vs=%b fs=%b addr=%0d/%0d, expected 000 1 1 0 0",
                 i, rgb_a, rgb_b, hs_a, vs_a, fs_a, addr_a, addr_b);
      end
      tick(1'b1, 300 + i, 200, 1'b1, 1'b1, 1'b0);
    end
    rst_n = 1'b1;
    reset_hist();
    for (int c = 305; c < 640; c++) tick(1'b1, c, 200, 1'b1, 1'b1, 1'b0);
    hblank(1'b1);
    test_full_frame("post_reset");
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4800; i++) field_a[i] = 1'($urandom % 2);
    for (int i = 0; i < 4200; i++) field_b[i] = 1'($urandom % 2);
    field_a[0] = 1'b1;
    field_b[0] = 1'b1;
    reset_hist();
    rst_n       = 1'b0;
    draw_active = 1'b0;
    active_x    = '0;
    active_y    = '0;
    h_sync      = 1'b1;
    v_sync      = 1'b1;
    @(negedge clk);
    test_reset();
    test_alive_cell();
    test_cell_mapping();
    test_full_frame("frame");
    test_border_70();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
